hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_if.sv | 29 ++
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath is the master: it drives the hazard inputs and reads back flush/stall.
interface hazard_ctrl_if #(
    parameter int AW   = 3,
    parameter int NSRC = 2,
    parameter int NSTG = 4
);
    logic                 mem_read;
    logic [AW-1:0]        write_add;
    logic [NSRC*AW-1:0]   src_add;
    logic [NSRC-1:0]      src_valid;
    logic                 int_req;
    logic                 branch_taken;
    logic                 ret;
    logic [NSTG-1:0]      flush;
    logic                 stall;
    logic                 int_ack;
    logic                 busy;

    modport master (
        output mem_read, write_add, src_add, src_valid, int_req, branch_taken, ret,
        input  flush, stall, int_ack, busy
    );

    modport slave (
        input  mem_read, write_add, src_add, src_valid, int_req, branch_taken, ret,
        output flush, stall, int_ack, busy
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, interrupt entry, return and branch flushes.
// Every output is registered, so a hazard sampled on one edge takes effect from that same edge.
module hazard_ctrl #(
    parameter int AW      = 3,
    parameter int NSRC    = 2,
    parameter int NSTG    = 4,
    parameter int LU_CYC  = 1,
    parameter int INT_CYC = 2,
    parameter int RET_CYC = 2
) (
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave bus
);
    localparam int MAX_CYC = (LU_CYC > INT_CYC) ?
                             ((LU_CYC > RET_CYC) ? LU_CYC : RET_CYC) :
                             ((INT_CYC > RET_CYC) ? INT_CYC : RET_CYC);
    localparam int CW = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0]   LU_LOAD   = CW'(LU_CYC - 1);
    localparam logic [CW-1:0]   INT_LOAD  = CW'(INT_CYC - 1);
    localparam logic [CW-1:0]   RET_LOAD  = CW'(RET_CYC - 1);
    localparam logic [NSTG-1:0] FLUSH_FD  = NSTG'(1);
    localparam logic [NSTG-1:0] FLUSH_DE  = NSTG'(2);
    localparam logic [NSTG-1:0] FLUSH_INT = NSTG'(3);
    localparam logic [NSTG-1:0] FLUSH_RET = ~NSTG'(1);

    typedef enum logic [1:0] {IDLE, LU, INT, RET} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            int_pend;
    logic [NSTG-1:0] flush_q;
    logic            stall_q;
    logic            int_ack_q;
    logic            src_match;
    logic            lu_hit;

    always_comb begin
        src_match = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.src_valid[i] && (bus.src_add[i*AW +: AW] == bus.write_add)) begin
                src_match = 1'b1;
            end
        end
    end

    assign lu_hit = bus.mem_read & src_match;

    // A running sequence only counts down; its final edge falls through to the
    // idle priority chain so back-to-back sequences need no gap cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            int_pend  <= 1'b0;
            flush_q   <= '0;
            stall_q   <= 1'b0;
            int_ack_q <= 1'b0;
        end else if (state != IDLE && cnt != '0) begin
            cnt       <= cnt - CW'(1);
            int_ack_q <= 1'b0;
            if (bus.int_req) begin
                int_pend <= 1'b1;
            end
        end else if (lu_hit) begin
            state     <= LU;
            cnt       <= LU_LOAD;
            stall_q   <= 1'b1;
            flush_q   <= FLUSH_FD;
            int_ack_q <= 1'b0;
            if (bus.int_req) begin
                int_pend <= 1'b1;
            end
        end else if (int_pend || bus.int_req) begin
            state     <= INT;
            cnt       <= INT_LOAD;
            stall_q   <= 1'b1;
            flush_q   <= FLUSH_INT;
            int_ack_q <= 1'b1;
            int_pend  <= 1'b0;
        end else if (bus.ret) begin
            state     <= RET;
            cnt       <= RET_LOAD;
            stall_q   <= 1'b0;
            flush_q   <= FLUSH_RET;
            int_ack_q <= 1'b0;
        end else if (bus.branch_taken) begin
            state     <= IDLE;
            cnt       <= '0;
            stall_q   <= 1'b0;
            flush_q   <= FLUSH_DE;
            int_ack_q <= 1'b0;
        end else begin
            state     <= IDLE;
            cnt       <= '0;
            stall_q   <= 1'b0;
            flush_q   <= '0;
            int_ack_q <= 1'b0;
        end
    end

    assign bus.flush   = flush_q;
    assign bus.stall   = stall_q;
    assign bus.int_ack = int_ack_q;
    assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed hazard scenarios on two parameterisations,
// then random traffic checked against a remaining-cycles reference model.
module tb_hazard_ctrl;
    logic clk;
    logic rst;
    int   n_compared;
    int   n_mismatched;

    hazard_ctrl_if #(.AW(3), .NSRC(2), .NSTG(4)) bus ();
    hazard_ctrl_if #(.AW(4), .NSRC(3), .NSTG(5)) bus5 ();

    hazard_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    hazard_ctrl #(.AW(4), .NSRC(3), .NSTG(5), .LU_CYC(2)) u_dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: cycles of the current sequence still to be shown, plus expected outputs.
    int         m_left;
    logic [3:0] m_flush;
    logic       m_stall;
    logic       m_ack;
    logic       m_pend;
    logic [2:0] cur_src [2];

    task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_left  = 0;
        m_flush = '0;
        m_stall = 1'b0;
        m_ack   = 1'b0;
        m_pend  = 1'b0;
    endtask

    task automatic model_step();
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (bus.src_valid[i] && cur_src[i] == bus.write_add) hit = 1'b1;
        end
        hit = hit && bus.mem_read;
        m_ack = 1'b0;
        if (m_left > 1) begin
            m_left = m_left - 1;
            m_pend = m_pend | bus.int_req;
        end else if (hit) begin
            m_left  = 1;
            m_stall = 1'b1;
            m_flush = 4'b0001;
            m_pend  = m_pend | bus.int_req;
        end else if (m_pend || bus.int_req) begin
            m_left  = 2;
            m_stall = 1'b1;
            m_flush = 4'b0011;
            m_ack   = 1'b1;
            m_pend  = 1'b0;
        end else if (bus.ret) begin
            m_left  = 2;
            m_stall = 1'b0;
            m_flush = 4'b1110;
        end else if (bus.branch_taken) begin
            m_left  = 0;
            m_stall = 1'b0;
            m_flush = 4'b0010;
        end else begin
            m_left  = 0;
            m_stall = 1'b0;
            m_flush = 4'b0000;
        end
    endtask

    task automatic apply_stimulus(input logic mr, input logic [2:0] wa, input logic [2:0] s1,
                                  input logic [2:0] s0, input logic [1:0] sv,
                                  input logic ir, input logic bt, input logic rt);
        bus.mem_read     = mr;
        bus.write_add    = wa;
        cur_src[0]       = s0;
        cur_src[1]       = s1;
        bus.src_add      = {s1, s0};
        bus.src_valid    = sv;
        bus.int_req      = ir;
        bus.branch_taken = bt;
        bus.ret          = rt;
    endtask

    task automatic apply_idle();
        apply_stimulus(1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_stimulus5(input logic mr, input logic [3:0] wa, input logic [11:0] sa,
                                   input logic [2:0] sv, input logic rt);
        bus5.mem_read     = mr;
        bus5.write_add    = wa;
        bus5.src_add      = sa;
        bus5.src_valid    = sv;
        bus5.int_req      = 1'b0;
        bus5.branch_taken = 1'b0;
        bus5.ret          = rt;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_outputs(input string tag, input logic [3:0] fl, input logic st,
                                  input logic ack, input logic bsy);
        check_output({tag, "_flush"}, 32'(bus.flush), 32'(fl));
        check_output({tag, "_stall"}, 32'(bus.stall), 32'(st));
        check_output({tag, "_ack"}, 32'(bus.int_ack), 32'(ack));
        check_output({tag, "_busy"}, 32'(bus.busy), 32'(bsy));
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        model_reset();
        apply_idle();
        apply_stimulus5(1'b0, 4'd0, 12'd0, 3'b000, 1'b0);
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        expect_outputs("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
        check_output("reset_flush5", 32'(bus5.flush), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Load-use: operand 1 (address 3) matches the load destination.
        apply_stimulus(1'b1, 3'd3, 3'd3, 3'd5, 2'b11, 1'b0, 1'b0, 1'b0);
        tick();
        apply_idle();
        expect_outputs("lu_c1", 4'b0001, 1'b1, 1'b0, 1'b1);
        tick();
        expect_outputs("lu_end", 4'b0000, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 3'd3, 3'd3, 3'd5, 2'b01, 1'b0, 1'b0, 1'b0);
        tick();
        apply_idle();
        expect_outputs("lu_nohit", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Interrupt pulse.
        apply_stimulus(1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        apply_idle();
        expect_outputs("int_c1", 4'b0011, 1'b1, 1'b1, 1'b1);
        tick();
        expect_outputs("int_c2", 4'b0011, 1'b1, 1'b0, 1'b1);
        tick();
        expect_outputs("int_end", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Return, with a branch arriving while the return sequence runs.
        apply_stimulus(1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 1'b1);
        tick();
        apply_stimulus(1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        expect_outputs("ret_c1", 4'b1110, 1'b0, 1'b0, 1'b1);
        tick();
        apply_idle();
        expect_outputs("ret_c2", 4'b1110, 1'b0, 1'b0, 1'b1);
        tick();
        expect_outputs("ret_end", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Branch alone: single-cycle DE flush.
        apply_stimulus(1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b1, 1'b0);
        tick();
        apply_idle();
        expect_outputs("br_c1", 4'b0010, 1'b0, 1'b0, 1'b0);
        tick();
        expect_outputs("br_end", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Load-use hit and interrupt together: LU first, INT abutting.
        apply_stimulus(1'b1, 3'd3, 3'd3, 3'd5, 2'b11, 1'b1, 1'b0, 1'b0);
        tick();
        apply_idle();
        expect_outputs("both_lu", 4'b0001, 1'b1, 1'b0, 1'b1);
        tick();
        expect_outputs("both_int1", 4'b0011, 1'b1, 1'b1, 1'b1);
        tick();
        expect_outputs("both_int2", 4'b0011, 1'b1, 1'b0, 1'b1);
        tick();
        expect_outputs("both_end", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Reset in the first cycle of an interrupt sequence.
        apply_stimulus(1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b1, 1'b0, 1'b0);
        tick();
        apply_idle();
        expect_outputs("rstmid_pre", 4'b0011, 1'b1, 1'b1, 1'b1);
        rst = 1'b0;
        #1;
        model_reset();
        expect_outputs("rstmid_async", 4'b0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        expect_outputs("rstmid_rel1", 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        expect_outputs("rstmid_rel2", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Wider instance: hit on operand 2, two-cycle load-use stall, then a return.
        apply_stimulus5(1'b1, 4'd9, {4'd9, 4'd2, 4'd1}, 3'b100, 1'b0);
        tick();
        apply_stimulus5(1'b0, 4'd0, 12'd0, 3'b000, 1'b0);
        check_output("p5_lu_c1_stall", 32'(bus5.stall), 32'd1);
        check_output("p5_lu_c1_flush", 32'(bus5.flush), 32'b00001);
        tick();
        check_output("p5_lu_c2_stall", 32'(bus5.stall), 32'd1);
        tick();
        check_output("p5_lu_end_stall", 32'(bus5.stall), 32'd0);
        apply_stimulus5(1'b0, 4'd0, 12'd0, 3'b000, 1'b1);
        tick();
        apply_stimulus5(1'b0, 4'd0, 12'd0, 3'b000, 1'b0);
        check_output("p5_ret_flush", 32'(bus5.flush), 32'b11110);
        check_output("p5_ret_stall", 32'(bus5.stall), 32'd0);

        // Random traffic against the reference model.
        tick();
        tick();
        for (int n = 0; n < 400; n++) begin
            apply_stimulus(($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)),
                           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                           2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                           ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
            tick();
            expect_outputs("rnd", m_flush, m_stall, m_ack, (m_left > 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
